// File: rtl/uart_report_fmt_pkg.sv
// Shared definitions for the report formatter: modes, FSM states, ASCII
// constants, message lengths and the BCD-to-ASCII digit mapping.
package uart_report_fmt_pkg;

   typedef enum logic [1:0] {
      MODE_WATCH     = 2'b00,
      MODE_STOPWATCH = 2'b01,
      MODE_DIST      = 2'b10,
      MODE_DHT       = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONV_A,
      ST_CONV_B,
      ST_SEND,
      ST_DONE
   } state_e;

   localparam logic [7:0] ASC_ZERO  = 8'h30, ASC_COLON = 8'h3A, ASC_DOT   = 8'h2E,
                          ASC_CR    = 8'h0D, ASC_LF    = 8'h0A, ASC_QMARK = 8'h3F,
                          ASC_PCT   = 8'h25, ASC_SPACE = 8'h20, ASC_W     = 8'h57,
                          ASC_S     = 8'h53, ASC_D     = 8'h44, ASC_H     = 8'h48,
                          ASC_T     = 8'h54, ASC_LC_C  = 8'h63, ASC_LC_M  = 8'h6D,
                          ASC_C     = 8'h43;

   localparam int LEN_WATCH     = 12;
   localparam int LEN_STOPWATCH = 12;
   localparam int LEN_DIST      = 11;
   localparam int LEN_DHT       = 16;

   // Invalid digits from the time sources are shown as '?' rather than garbage.
   function automatic logic [7:0] bcd_asc(input logic [3:0] d);
      return (d > 4'd9) ? ASC_QMARK : (ASC_ZERO + {4'd0, d});
   endfunction

   function automatic logic [3:0] last_idx(input mode_e m);
      case (m)
         MODE_WATCH:     return 4'(LEN_WATCH - 1);
         MODE_STOPWATCH: return 4'(LEN_STOPWATCH - 1);
         MODE_DIST:      return 4'(LEN_DIST - 1);
         default:        return 4'(LEN_DHT - 1);
      endcase
   endfunction

endpackage

// File: rtl/uart_report_fmt_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle,
// NUM_W binary bits in, four BCD digits out, done pulses NUM_W+1 cycles after start.
module bin2bcd_seq #(
   parameter int NUM_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_bin,
   output logic             o_done,
   output logic [15:0]      o_bcd
);
   import uart_report_fmt_pkg::*;

   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [NUM_W+15:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              run_q;
   logic              done_q;
   logic [3:0]        dig_adj [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign dig_adj[gi] = (shift_q[NUM_W+4*gi +: 4] >= 4'd5) ?
                           shift_q[NUM_W+4*gi +: 4] + 4'd3 : shift_q[NUM_W+4*gi +: 4];
   end

   assign shift_d = {dig_adj[3][2:0], dig_adj[2], dig_adj[1], dig_adj[0],
                     shift_q[NUM_W-1:0], 1'b0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // A start while running is dropped; the caller never issues one.
         if (i_start && !run_q) begin
            shift_q <= {16'd0, i_bin};
            cnt_q   <= CNT_W'(NUM_W);
            run_q   <= 1'b1;
         end else if (run_q) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign o_done = done_q;
   assign o_bcd  = shift_q[NUM_W +: 16];

endmodule

// File: rtl/uart_report_fmt.sv
// Formats a snapshot of watch/stopwatch/distance/DHT11 data into one ASCII
// line and streams it to the UART transmitter over a valid/ready byte port.
module uart_report_fmt #(
   parameter int NUM_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [1:0]  i_mode,
   input  logic [23:0] i_watch_bcd,
   input  logic [23:0] i_stopwatch_bcd,
   input  logic [9:0]  i_dist,
   input  logic [7:0]  i_rh,
   input  logic [7:0]  i_t,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic        o_done
);
   import uart_report_fmt_pkg::*;

   state_e      state_q;
   mode_e       mode_q;
   logic [23:0] watch_q, sw_q;
   logic [7:0]  t_q;
   logic [15:0] a_q, b_q;
   logic [3:0]  idx_q;
   logic [7:0]  data_q;
   logic        valid_q, busy_q, done_q;

   logic             conv_start, conv_done;
   logic [NUM_W-1:0] conv_in;
   logic [15:0]      conv_bcd;

   function automatic logic [7:0] msg_byte(input mode_e m, input logic [3:0] idx,
                                           input logic [23:0] w, input logic [23:0] s,
                                           input logic [15:0] a, input logic [15:0] b);
      logic [7:0]  c;
      logic [23:0] v;
      c = ASC_SPACE;
      v = (m == MODE_WATCH) ? w : s;
      case (m)
         MODE_WATCH, MODE_STOPWATCH:
            case (idx)
               4'd0:       c = (m == MODE_WATCH) ? ASC_W : ASC_S;
               4'd1, 4'd4: c = ASC_COLON;
               4'd2:       c = bcd_asc(v[23:20]);
               4'd3:       c = bcd_asc(v[19:16]);
               4'd5:       c = bcd_asc(v[15:12]);
               4'd6:       c = bcd_asc(v[11:8]);
               4'd7:       c = (m == MODE_WATCH) ? ASC_COLON : ASC_DOT;
               4'd8:       c = bcd_asc(v[7:4]);
               4'd9:       c = bcd_asc(v[3:0]);
               4'd10:      c = ASC_CR;
               4'd11:      c = ASC_LF;
               default:    c = ASC_SPACE;
            endcase
         MODE_DIST:
            case (idx)
               4'd0:    c = ASC_D;
               4'd1:    c = ASC_COLON;
               4'd2:    c = bcd_asc(a[15:12]);
               4'd3:    c = bcd_asc(a[11:8]);
               4'd4:    c = bcd_asc(a[7:4]);
               4'd5:    c = bcd_asc(a[3:0]);
               4'd7:    c = ASC_LC_C;
               4'd8:    c = ASC_LC_M;
               4'd9:    c = ASC_CR;
               4'd10:   c = ASC_LF;
               default: c = ASC_SPACE;
            endcase
         default:
            case (idx)
               4'd0:    c = ASC_H;
               4'd1:    c = ASC_COLON;
               4'd2:    c = bcd_asc(a[11:8]);
               4'd3:    c = bcd_asc(a[7:4]);
               4'd4:    c = bcd_asc(a[3:0]);
               4'd5:    c = ASC_PCT;
               4'd7:    c = ASC_T;
               4'd8:    c = ASC_COLON;
               4'd9:    c = bcd_asc(b[11:8]);
               4'd10:   c = bcd_asc(b[7:4]);
               4'd11:   c = bcd_asc(b[3:0]);
               4'd13:   c = ASC_C;
               4'd14:   c = ASC_CR;
               4'd15:   c = ASC_LF;
               default: c = ASC_SPACE;
            endcase
      endcase
      return c;
   endfunction

   // The first conversion starts on the request edge itself from the live
   // inputs, so the converter register doubles as the distance/humidity snapshot.
   assign conv_start = ((state_q == ST_IDLE) && i_req && i_mode[1]) ||
                       ((state_q == ST_CONV_A) && conv_done && (mode_q == MODE_DHT));

   always_comb begin
      conv_in = NUM_W'(t_q);
      if (state_q == ST_IDLE)
         conv_in = (i_mode == MODE_DIST) ? NUM_W'(i_dist) : NUM_W'(i_rh);
   end

   bin2bcd_seq #(.NUM_W(NUM_W)) u_conv (
      .clk     (clk),
      .rst     (rst),
      .i_start (conv_start),
      .i_bin   (conv_in),
      .o_done  (conv_done),
      .o_bcd   (conv_bcd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_WATCH;
         watch_q <= '0;
         sw_q    <= '0;
         t_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE:
               if (i_req) begin
                  mode_q  <= mode_e'(i_mode);
                  watch_q <= i_watch_bcd;
                  sw_q    <= i_stopwatch_bcd;
                  t_q     <= i_t;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  if (i_mode[1]) begin
                     state_q <= ST_CONV_A;
                  end else begin
                     state_q <= ST_SEND;
                     valid_q <= 1'b1;
                     data_q  <= msg_byte(mode_e'(i_mode), 4'd0, i_watch_bcd,
                                         i_stopwatch_bcd, a_q, b_q);
                  end
               end
            ST_CONV_A:
               if (conv_done) begin
                  a_q <= conv_bcd;
                  if (mode_q == MODE_DHT) begin
                     state_q <= ST_CONV_B;
                  end else begin
                     state_q <= ST_SEND;
                     valid_q <= 1'b1;
                     data_q  <= msg_byte(mode_q, 4'd0, watch_q, sw_q, conv_bcd, b_q);
                  end
               end
            ST_CONV_B:
               if (conv_done) begin
                  b_q     <= conv_bcd;
                  state_q <= ST_SEND;
                  valid_q <= 1'b1;
                  data_q  <= msg_byte(mode_q, 4'd0, watch_q, sw_q, a_q, conv_bcd);
               end
            ST_SEND:
               if (i_tx_ready) begin
                  idx_q <= idx_q + 4'd1;
                  if (idx_q == last_idx(mode_q)) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     data_q <= msg_byte(mode_q, idx_q + 4'd1, watch_q, sw_q, a_q, b_q);
                  end
               end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_tx_data  = data_q;
   assign o_tx_valid = valid_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule

// File: tb/tb_uart_report_fmt.sv
// Scoreboard bench for uart_report_fmt: directed requests push the expected
// ASCII line; a negedge monitor pops and compares every accepted byte.
module tb_uart_report_fmt;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [1:0]  i_mode = 2'b00;
   logic [23:0] i_watch_bcd = '0;
   logic [23:0] i_stopwatch_bcd = '0;
   logic [9:0]  i_dist = '0;
   logic [7:0]  i_rh = '0;
   logic [7:0]  i_t = '0;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready = 1'b1;
   logic        o_busy;
   logic        o_done;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   bit          toggle_ready = 1'b0;
   logic [7:0]  exp_q [$];
   bit          stall_prev = 1'b0;
   logic [7:0]  held_data = '0;

   uart_report_fmt #(.NUM_W(10)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_req           (i_req),
      .i_mode          (i_mode),
      .i_watch_bcd     (i_watch_bcd),
      .i_stopwatch_bcd (i_stopwatch_bcd),
      .i_dist          (i_dist),
      .i_rh            (i_rh),
      .i_t             (i_t),
      .o_tx_data       (o_tx_data),
      .o_tx_valid      (o_tx_valid),
      .i_tx_ready      (i_tx_ready),
      .o_busy          (o_busy),
      .o_done          (o_done)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      i_tx_ready = toggle_ready ? ~i_tx_ready : 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // Monitor: byte transfers, data stability under back-pressure, done pulses.
   always @(negedge clk) begin
      if (rst) begin
         if (o_done) done_cnt++;
         if (stall_prev && o_tx_valid)
            chk("stable_data", int'(o_tx_data), int'(held_data));
         if (o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_byte: got 0x%02h, required no byte", o_tx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               chk("tx_byte", int'(o_tx_data), int'(e));
               $display("byte 0x%02h expected 0x%02h", o_tx_data, e);
            end
         end
         stall_prev = o_tx_valid && !i_tx_ready;
         held_data  = o_tx_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic push_line(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic pulse_req(input logic [1:0] m);
      @(posedge clk);
      #1;
      i_mode = m;
      i_req  = 1'b1;
      @(posedge clk);
      #1;
      i_req = 1'b0;
   endtask

   // Returns the inclusive cycle count from the request cycle to the o_done cycle, 0 on timeout.
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (o_done) begin
            cyc = k + 1;
            break;
         end
      end
   endtask

   task automatic run_msg(input logic [1:0] m, input string s, input int exp_cyc);
      int cyc;
      push_line(s);
      done_cnt = 0;
      pulse_req(m);
      wait_done(cyc);
      chk("done_seen", int'(cyc != 0), 1);
      if (exp_cyc > 0) chk("latency", cyc, exp_cyc);
      @(negedge clk);
      chk("done_one_cycle", int'(o_done), 0);
      chk("busy_after", int'(o_busy), 0);
      chk("bytes_left", exp_q.size(), 0);
      chk("done_count", done_cnt, 1);
      $display("message mode=%0d \"%s\" done after %0d cycles", m, s, cyc);
      exp_q.delete();
   endtask

   initial begin
      int cyc;
      bit hit;

      // Reset state
      @(negedge clk);
      chk("rst_valid", int'(o_tx_valid), 0);
      chk("rst_data", int'(o_tx_data), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      @(posedge clk);
      #1 rst = 1'b1;

      i_watch_bcd = 24'h123456;
      run_msg(2'b00, "W:12:34:56", 14);

      toggle_ready = 1'b1;
      i_dist = 10'd1023;
      run_msg(2'b10, "D:1023 cm", 0);
      toggle_ready = 1'b0;

      i_rh = 8'd45;
      i_t  = 8'd7;
      run_msg(2'b11, "H:045% T:007 C", 40);

      i_stopwatch_bcd = 24'h0A5999;
      run_msg(2'b01, "S:0?:59.99", 14);

      // Second request mid-message with new watch data: ignored entirely
      i_watch_bcd = 24'h123456;
      push_line("W:12:34:56");
      done_cnt = 0;
      pulse_req(2'b00);
      repeat (3) @(posedge clk);
      #1;
      i_watch_bcd = 24'h987654;
      i_dist = 10'd5;
      i_mode = 2'b10;
      i_req  = 1'b1;
      @(posedge clk);
      #1 i_req = 1'b0;
      wait_done(cyc);
      chk("busy_req_done_seen", int'(cyc != 0), 1);
      repeat (30) @(negedge clk);
      chk("busy_req_idle", int'(o_busy), 0);
      chk("busy_req_valid", int'(o_tx_valid), 0);
      chk("busy_req_bytes_left", exp_q.size(), 0);
      chk("busy_req_done_count", done_cnt, 1);
      $display("message with ignored second request finished");
      exp_q.delete();

      // Asynchronous reset right after the 5th byte is accepted
      i_watch_bcd = 24'h112233;
      exp_q.push_back("W");
      exp_q.push_back(":");
      exp_q.push_back("1");
      exp_q.push_back("1");
      exp_q.push_back(":");
      pulse_req(2'b00);
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) begin
            hit = 1'b1;
            break;
         end
      end
      chk("five_bytes_seen", int'(hit), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("async_rst_valid", int'(o_tx_valid), 0);
      chk("async_rst_busy", int'(o_busy), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      $display("reset applied after 5th byte");

      i_watch_bcd = 24'h235900;
      run_msg(2'b00, "W:23:59:00", 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
